// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue for a MIPS32-style front end: issues word fetches to a
// 1-cycle-latency instruction memory, buffers returned words and hands them to decode.
module mips32_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [9:0] RESET_PC = 10'd0
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [9:0]  redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ir,
    output logic [31:0] id_npc
);

    localparam int         PW      = $clog2(DEPTH);
    localparam int         CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [5:0] HLT_OP  = 6'b111111;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [9:0]    pc;
    logic [9:0]    req_addr;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   ir_q  [DEPTH];
    logic [9:0]    npc_q [DEPTH];
    logic          push;
    logic          pop;
    logic          hlt_return;

    // A redirect in the same cycle kills the returning word, so it never counts as pushed.
    assign push       = inflight && !redirect_valid;
    assign hlt_return = push && (imem_rdata[31:26] == HLT_OP);
    assign pop        = id_valid && id_ready;
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};

    assign imem_addr = pc;
    assign id_valid  = (count != '0) && !redirect_valid;
    assign id_ir     = ir_q[head];
    assign id_npc    = {22'b0, npc_q[head]};

    // Fetching also pauses in the cycle a HLT returns, so nothing past the HLT is requested.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        if (redirect_valid) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (hlt_return) begin
                        state_next = STOP;
                    end else begin
                        imem_req = rst_n && (occupancy < DEPTH_W);
                    end
                end
                STOP: begin
                    state_next = STOP;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            req_addr <= '0;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ir_q[i]  <= '0;
                npc_q[i] <= '0;
            end
        end else begin
            state    <= state_next;
            inflight <= imem_req;
            if (imem_req) begin
                pc       <= pc + 10'd1;
                req_addr <= pc;
            end
            if (redirect_valid) begin
                pc    <= redirect_pc;
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) begin
                    ir_q[tail]  <= imem_rdata;
                    npc_q[tail] <= req_addr + 10'd1;
                    tail        <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: directed phases plus random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_mips32_fetch_queue;

    localparam int         DEPTH  = 4;
    localparam logic [5:0] HLT_OP = 6'b111111;

    logic        clk1;
    logic        rst_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;

    logic        w_rst_n;
    logic        w_req;
    logic [9:0]  w_addr;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [9:0]  w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_ir;
    logic [31:0] w_npc;

    logic [31:0] mem [1024];

    typedef struct packed {
        logic [31:0] ir;
        logic [9:0]  npc;
    } entry_t;

    entry_t      mq[$];
    entry_t      dq[$];
    int unsigned req_addrs[$];
    int unsigned m_pc;
    bit          m_inflight;
    int unsigned m_inf_addr;
    bit          m_halted;
    int          checks = 0;
    int          failures = 0;
    int          cyc;
    int          first_valid_cycle;
    int          req_count;

    mips32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(10'd0)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_npc(id_npc)
    );

    mips32_fetch_queue #(.DEPTH(2), .RESET_PC(10'd1022)) dut_wrap (
        .clk1(clk1), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .id_valid(w_valid), .id_ready(w_ready), .id_ir(w_ir), .id_npc(w_npc)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Instruction memory: word appears the cycle after the request; garbage otherwise.
    always @(posedge clk1) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
        else          imem_rdata <= $urandom;
        if (w_req) w_rdata <= mem[w_addr];
        else       w_rdata <= $urandom;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset(input int unsigned pc);
        mq.delete();
        m_pc       = pc;
        m_inflight = 1'b0;
        m_inf_addr = 0;
        m_halted   = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model.
    task automatic applyStimulus(input bit rdy, input bit rv, input logic [9:0] rpc);
        bit     exp_valid;
        bit     exp_req;
        bit     hlt_back;
        entry_t head;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        cyc++;
        hlt_back  = m_inflight && (mem[m_inf_addr][31:26] == HLT_OP);
        exp_valid = (mq.size() != 0) && !rv;
        exp_req   = !m_halted && !rv && !hlt_back && ((mq.size() + int'(m_inflight)) < DEPTH);
        checkOutput("imem_req", imem_req, exp_req);
        if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("id_valid", id_valid, exp_valid);
        if (exp_valid) begin
            head = mq[0];
            checkOutput("id_ir", id_ir, head.ir);
            checkOutput("id_npc", id_npc, {22'b0, head.npc});
        end
        if (id_valid === 1'b1 && first_valid_cycle == 0) first_valid_cycle = cyc;
        if (imem_req === 1'b1) begin
            req_count++;
            req_addrs.push_back(imem_addr);
        end
        if (id_valid === 1'b1 && rdy) dq.push_back('{ir: id_ir, npc: id_npc[9:0]});
        if (rv) begin
            modelReset(rpc);
        end else begin
            if (exp_valid && rdy) head = mq.pop_front();
            if (m_inflight) begin
                mq.push_back('{ir: mem[m_inf_addr], npc: 10'((m_inf_addr + 1) % 1024)});
                if (hlt_back) m_halted = 1'b1;
            end
            if (exp_req) begin
                m_inflight = 1'b1;
                m_inf_addr = m_pc;
                m_pc       = (m_pc + 1) % 1024;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(posedge clk1);
        @(negedge clk1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] saved2;
        int unsigned wa[$];
        logic [31:0] wn[$];
        logic [31:0] wi[$];

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            w[7:0] = i[7:0];
            if (w[31:26] == HLT_OP) w[26] = 1'b0;
            mem[i] = w;
        end
        rst_n = 1'b0;
        w_rst_n = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        w_redirect = 1'b0;
        w_redirect_pc = '0;
        w_ready = 1'b1;
        cyc = 0;
        first_valid_cycle = 0;
        req_count = 0;
        repeat (2) @(negedge clk1);

        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_id_valid", id_valid, 0);
        checkOutput("rst_id_ir", id_ir, 0);
        checkOutput("rst_id_npc", id_npc, 0);
        modelReset(0);
        rst_n = 1'b1;

        // Streaming with decode always ready
        dq.delete();
        repeat (10) applyStimulus(1, 0, 0);
        checkOutput("stream_first_valid_cycle", first_valid_cycle, 3);
        checkOutput("stream_delivered", dq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput("stream_ir", dq[k].ir, mem[k]);
            checkOutput("stream_npc", {22'b0, dq[k].npc}, k + 1);
        end

        // Backpressure
        dq.delete();
        applyStimulus(0, 1, 0);
        req_count = 0;
        req_addrs.delete();
        repeat (10) applyStimulus(0, 0, 0);
        checkOutput("bp_req_count", req_count, 4);
        for (int k = 0; k < 4; k++) checkOutput("bp_addr", req_addrs[k], k);
        req_addrs.delete();
        repeat (8) applyStimulus(1, 0, 0);
        for (int k = 0; k < 4; k++) checkOutput("bp_drain_ir", dq[k].ir, mem[k]);
        checkOutput("bp_resume_addr", req_addrs[0], 4);

        // Redirect with 3 queued and 1 in flight
        applyStimulus(0, 1, 0);
        repeat (4) applyStimulus(0, 0, 0);
        dq.delete();
        applyStimulus(1, 1, 10'd100);
        repeat (6) applyStimulus(1, 0, 0);
        checkOutput("redir_ir0", dq[0].ir, mem[100]);
        checkOutput("redir_npc0", {22'b0, dq[0].npc}, 101);
        checkOutput("redir_ir1", dq[1].ir, mem[101]);

        // Back-to-back redirects: the later target wins
        dq.delete();
        applyStimulus(1, 1, 10'd200);
        applyStimulus(1, 1, 10'd300);
        repeat (5) applyStimulus(1, 0, 0);
        checkOutput("b2b_ir0", dq[0].ir, mem[300]);
        checkOutput("b2b_npc0", {22'b0, dq[0].npc}, 301);

        // Halt at word 2, then restart by redirect to 5
        saved2 = mem[2];
        mem[2] = 32'hFC000000;
        applyStimulus(0, 1, 0);
        dq.delete();
        req_count = 0;
        req_addrs.delete();
        repeat (10) applyStimulus(1, 0, 0);
        checkOutput("halt_delivered", dq.size(), 3);
        checkOutput("halt_ir2", dq[2].ir, 32'hFC000000);
        checkOutput("halt_req_count", req_count, 3);
        req_addrs.delete();
        applyStimulus(1, 1, 10'd5);
        repeat (3) applyStimulus(1, 0, 0);
        checkOutput("halt_resume_addr", req_addrs[0], 5);
        mem[2] = saved2;

        // Random traffic with a few HLT words planted
        for (int k = 0; k < 8; k++) mem[$urandom_range(1000, 8)][31:26] = HLT_OP;
        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom_range(99) < 70, $urandom_range(99) < 5, 10'($urandom_range(1023)));
        end

        // Asynchronous reset between clock edges
        applyStimulus(1, 1, 0);
        repeat (5) applyStimulus(1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_imem_req", imem_req, 0);
        checkOutput("arst_id_valid", id_valid, 0);
        checkOutput("arst_id_ir", id_ir, 0);
        checkOutput("arst_id_npc", id_npc, 0);
        modelReset(0);
        @(negedge clk1);
        rst_n = 1'b1;
        dq.delete();
        repeat (5) applyStimulus(1, 0, 0);
        checkOutput("arst_first_ir", dq[0].ir, mem[0]);
        checkOutput("arst_first_npc", {22'b0, dq[0].npc}, 1);

        // Address wrap on the RESET_PC=1022 instance
        id_ready = 1'b0;
        w_rst_n = 1'b1;
        repeat (12) begin
            #1;
            if (w_req === 1'b1) wa.push_back(w_addr);
            if (w_valid === 1'b1) begin
                wn.push_back(w_npc);
                wi.push_back(w_ir);
            end
            @(posedge clk1);
            @(negedge clk1);
        end
        checkOutput("wrap_addr0", wa[0], 1022);
        checkOutput("wrap_addr1", wa[1], 1023);
        checkOutput("wrap_addr2", wa[2], 0);
        checkOutput("wrap_addr3", wa[3], 1);
        checkOutput("wrap_npc0", wn[0], 1023);
        checkOutput("wrap_npc1", wn[1], 0);
        checkOutput("wrap_npc2", wn[2], 1);
        checkOutput("wrap_npc3", wn[3], 2);
        checkOutput("wrap_ir1", wi[1], mem[1023]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the prefetch queue entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 10'd0, setting the word address fetched first after reset.
REQ-003 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request to the 1024-word instruction memory.
REQ-006 imem_addr  output  10  word address of the current request.
REQ-007 imem_rdata  input  32  instruction word, valid on the cycle after the request.
REQ-008 redirect_valid  input  1  taken-branch redirect from EX/MEM.
REQ-009 redirect_pc  input  10  branch target word address.
REQ-010 id_valid  output  1  head entry available to decode.
REQ-011 id_ready  input  1  decode accepts the head entry.
REQ-012 id_ir  output  32  head instruction word.
REQ-013 id_npc  output  32  head fetch address + 1, zero-extended.

Function
REQ-014 A pop SHALL occur when id_valid and id_ready are both 1, removing the head entry.
REQ-015 imem_req SHALL be 1 only when all hold: state RUN, redirect_valid=0, rst_n=1, and (count + inflight) < DEPTH.
REQ-016 imem_addr SHALL equal the fetch PC; PC SHALL advance by 1 on each issued request, wrapping 1023 -> 0.
REQ-017 inflight SHALL be 1 on the cycle after a request and 0 otherwise; a 1-cycle memory latency is fixed.
REQ-018 A returning word SHALL be pushed at the tail with npc = {22'b0, addr+1 mod 1024}, unless killed by REQ-021.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; the queue never overflows, by REQ-015.
REQ-020 id_valid SHALL be (count != 0) and redirect_valid=0; id_ir/id_npc SHALL be driven from the head register with no combinational path from imem_rdata.
REQ-021 redirect_valid=1 SHALL, in that cycle, empty the queue, kill any in-flight response, ignore id_ready, load PC with redirect_pc, and set state RUN.
REQ-022 After redirect, the first request SHALL issue on the next cycle at redirect_pc; id_valid SHALL rise 2 cycles after that request.
REQ-023 State machine: RUN (fetching) and STOP; RUN -> STOP when a pushed word has opcode [31:26] = 6'b111111 (HLT).
REQ-024 In STOP no requests SHALL issue, while queued entries, including the HLT, SHALL still drain to decode.
REQ-025 STOP -> RUN SHALL occur only on redirect_valid or reset; a killed HLT word SHALL NOT cause STOP.
REQ-026 Back-to-back redirects SHALL each apply fully; the last one wins.
REQ-027 With id_ready held at 1 in RUN, sustained throughput SHALL be one instruction per cycle.

Reset
REQ-028 While rst_n=0: PC=RESET_PC, count=0, inflight=0, state RUN, imem_req=0, id_valid=0, id_ir=0, id_npc=0, all queue storage 0.
REQ-029 Reset asserted mid-operation SHALL discard queued and in-flight words immediately, without waiting for a clock edge.
REQ-030 On the first clk1 edge after rst_n rises, imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-031 Stream: Mem[0..7] = distinct words, id_ready=1 -> id_valid rises cycle 3; ir=Mem[0..7] in order, npc=1..8, one per cycle.
REQ-032 Backpressure: id_ready=0 for 10 cycles -> exactly 4 requests (addr 0..3), count=4, imem_req=0; release -> words 0..3, then fetch resumes at addr 4.
REQ-033 Redirect: redirect_pc=10'd100 while 3 entries are queued and 1 is in flight -> id_valid=0 that cycle; the next delivered word is Mem[100] with npc=101; no stale words appear.
REQ-034 Halt: Mem[2]=32'hFC000000 -> words 0,1,2 delivered, no request after addr 2 returns; redirect to 5 -> fetch resumes at 5.
REQ-035 Wrap: RESET_PC=1022 -> addresses 1022,1023,0,1; npc for 1023 = 0.
REQ-036 Async reset: rst_n low mid-stream, between edges -> id_valid and imem_req are 0 immediately; after release, the first word delivered is Mem[RESET_PC].
